// File: rtl/vga_pixel_fifo_if.sv
// Pixel stream handshake between the upstream pixel source and vga_pixel_fifo.
// master = pixel source, slave = FIFO.
interface vga_pixel_fifo_if;
  logic       pix_valid;
  logic [2:0] pix_data;   // {r,g,b}
  logic       pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: buffers 3-bit RGB pixels between the upstream source and the
// DAC pins, pops one pixel per active-video cycle, delays syncs to match colour,
// flags underflow and resynchronises the source at every vblank rise.
// Optional feature macro: VGA_PIXEL_FIFO_UNDERFLOW_CNT_EN builds the saturating
// starved-pixel counter; without it underflow_count is tied to 0.
module vga_pixel_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk50,
  input  logic                rst,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblank_in,
  input  logic                vblank_in,
  vga_pixel_fifo_if.slave     pix,
  output logic                frame_start,
  output logic                red_out,
  output logic                green_out,
  output logic                blue_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                underflow,
  output logic [7:0]          underflow_count
);

  typedef enum logic [1:0] {ST_WAIT, ST_FILL, ST_RUN, ST_RESYNC} state_t;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  logic [2:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_vblank_d;
  logic [2:0]        r_rgb;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_frame_start;
  logic              r_underflow;

  logic w_active;
  logic w_vb_rise;
  logic w_vb_fall;
  logic w_accepting;
  logic w_push;
  logic w_pop;
  logic w_starve;

  assign w_active    = !hblank_in && !vblank_in;
  assign w_vb_rise   = vblank_in && !r_vblank_d;
  assign w_vb_fall   = !vblank_in && r_vblank_d;
  assign w_accepting = (r_state == ST_FILL) || (r_state == ST_RUN);
  // A push on the vblank-rise cycle is dropped because that cycle flushes.
  assign w_push      = pix.pix_valid && pix.pix_ready && w_accepting && !w_vb_rise;
  // Only stored entries pop: a same-cycle push into an empty FIFO starves.
  assign w_pop       = w_active && (r_state == ST_RUN) && (r_count != '0);
  assign w_starve    = w_active && (r_state == ST_RUN) && (r_count == '0);

  // Ready depends on state and occupancy only; WAIT/RESYNC swallow input.
  always_comb begin
    if (rst) begin
      pix.pix_ready = 1'b0;
    end else begin
      case (r_state)
        ST_WAIT, ST_RESYNC: pix.pix_ready = 1'b1;
        ST_FILL, ST_RUN:    pix.pix_ready = (r_count != L_DEPTH);
        default:            pix.pix_ready = 1'b0;
      endcase
    end
  end

  // Pixel storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pix.pix_data;
    end
  end

  // FIFO pointers, state machine and the registered output stage.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_state       <= ST_WAIT;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_vblank_d    <= 1'b1;
      r_rgb         <= 3'b000;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_vblank_d    <= vblank_in;
      r_hsync       <= hsync_in;
      r_vsync       <= vsync_in;
      r_frame_start <= w_vb_rise;
      r_rgb         <= w_pop ? r_mem[r_rd_ptr] : 3'b000;
      if (w_starve) begin
        r_underflow <= 1'b1;
      end
      if (w_vb_rise) begin
        // Frame boundary: drop everything and let the source restart at (0,0).
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_state  <= ST_FILL;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        case (r_state)
          ST_WAIT:   r_state <= ST_WAIT;
          ST_FILL:   r_state <= w_vb_fall ? ST_RUN : ST_FILL;
          ST_RUN:    r_state <= w_starve ? ST_RESYNC : ST_RUN;
          ST_RESYNC: r_state <= ST_RESYNC;
          default:   r_state <= ST_WAIT;
        endcase
      end
    end
  end

`ifdef VGA_PIXEL_FIFO_UNDERFLOW_CNT_EN
  logic [7:0] r_uf_cnt;

  // Saturating count of starved active pixels.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_uf_cnt <= 8'd0;
    end else if (w_starve && (r_uf_cnt != 8'hFF)) begin
      r_uf_cnt <= r_uf_cnt + 8'd1;
    end else begin
      r_uf_cnt <= r_uf_cnt;
    end
  end

  assign underflow_count = r_uf_cnt;
`else
  assign underflow_count = 8'd0;
`endif

  assign frame_start = r_frame_start;
  assign red_out     = r_rgb[2];
  assign green_out   = r_rgb[1];
  assign blue_out    = r_rgb[0];
  assign hsync_out   = r_hsync;
  assign vsync_out   = r_vsync;
  assign underflow   = r_underflow;

endmodule
